// File: rtl/baud_tick_gen.sv
// baud_tick_gen: oversampled baud strobe generator (sample, mid-bit, bit).
// Optional BAUD_TICK_GEN_DIV_OVR_EN adds a direct terminal-count override.
module baud_tick_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int OVS    = 16,
    parameter int CNT_W  = 16,
    parameter int OVS_W  = $clog2(OVS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       baud_sel,
    input  logic             resync,
`ifdef BAUD_TICK_GEN_DIV_OVR_EN
    input  logic             div_ovr_sel,
    input  logic [CNT_W-1:0] div_ovr,
`endif
    output logic             sample_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic [OVS_W-1:0] sample_idx,
    output logic [CNT_W-1:0] div_val
);

    // Rounded divisor minus one, evaluated at elaboration only.
    function automatic logic [CNT_W-1:0] tc_calc(input longint baud);
        longint den;
        longint clk_l;
        den   = baud * longint'(OVS);
        clk_l = longint'(CLK_HZ);
        return CNT_W'((clk_l + den / 2) / den - 1);
    endfunction

    localparam logic [CNT_W-1:0] TC_300    = tc_calc(300);
    localparam logic [CNT_W-1:0] TC_1200   = tc_calc(1200);
    localparam logic [CNT_W-1:0] TC_4800   = tc_calc(4800);
    localparam logic [CNT_W-1:0] TC_9600   = tc_calc(9600);
    localparam logic [CNT_W-1:0] TC_19200  = tc_calc(19200);
    localparam logic [CNT_W-1:0] TC_38400  = tc_calc(38400);
    localparam logic [CNT_W-1:0] TC_57600  = tc_calc(57600);
    localparam logic [CNT_W-1:0] TC_115200 = tc_calc(115200);

    localparam logic [OVS_W-1:0] IDX_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] IDX_MID  = OVS_W'(OVS / 2 - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] table_tc;
    logic [CNT_W-1:0] next_tc;

    always_comb begin
        table_tc = TC_300;
        unique case (baud_sel)
            3'd0: table_tc = TC_300;
            3'd1: table_tc = TC_1200;
            3'd2: table_tc = TC_4800;
            3'd3: table_tc = TC_9600;
            3'd4: table_tc = TC_19200;
            3'd5: table_tc = TC_38400;
            3'd6: table_tc = TC_57600;
            3'd7: table_tc = TC_115200;
        endcase
    end

    always_comb begin
        next_tc = table_tc;
`ifdef BAUD_TICK_GEN_DIV_OVR_EN
        if (div_ovr_sel)
            next_tc = div_ovr;
`endif
    end

    // Divisor only reloads while disabled so a running bit never changes rate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            sample_idx  <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            div_val     <= TC_300;
        end else if (!enable) begin
            cnt         <= '0;
            sample_idx  <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            div_val     <= next_tc;
        end else if (resync) begin
            cnt         <= '0;
            sample_idx  <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
        end else if (cnt == div_val) begin
            cnt         <= '0;
            sample_tick <= 1'b1;
            mid_tick    <= (sample_idx == IDX_MID);
            bit_tick    <= (sample_idx == IDX_LAST);
            if (sample_idx == IDX_LAST)
                sample_idx <= '0;
            else
                sample_idx <= sample_idx + OVS_W'(1);
        end else begin
            cnt         <= cnt + CNT_W'(1);
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters.
// Override steps compile in only with BAUD_TICK_GEN_DIV_OVR_EN.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  baud_sel;
  logic        resync;
  logic        div_ovr_sel;
  logic [15:0] div_ovr;
  logic        sample_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  sample_idx;
  logic [15:0] div_val;

  int checks   = 0;
  int failures = 0;
  int ns = 0;
  int nm = 0;
  int nb = 0;

  baud_tick_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .baud_sel    (baud_sel),
    .resync      (resync),
`ifdef BAUD_TICK_GEN_DIV_OVR_EN
    .div_ovr_sel (div_ovr_sel),
    .div_ovr     (div_ovr),
`endif
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick),
    .sample_idx  (sample_idx),
    .div_val     (div_val)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] ex
  );
    checks++;
    if (obs !== ex) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, ex);
    end
  endtask

  task automatic clr();
    ns = 0;
    nm = 0;
    nb = 0;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sample_tick === 1'b1) ns++;
      if (mid_tick === 1'b1) nm++;
      if (bit_tick === 1'b1) nb++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    baud_sel    = 3'd0;
    resync      = 1'b0;
    div_ovr_sel = 1'b0;
    div_ovr     = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sample", sample_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_idx", sample_idx, 0);
    chk("rst_div", div_val, 10416);

    reset    = 1'b1;
    baud_sel = 3'd7;
    adv(1);
    chk("div_sel7", div_val, 26);
    chk("idx_disabled", sample_idx, 0);

    enable = 1'b1;
    clr();
    adv(26);
    chk("no_early_tick", ns, 0);
    adv(1);
    chk("first_tick", sample_tick, 1);
    chk("first_idx", sample_idx, 1);
    adv(1);
    chk("tick_width", sample_tick, 0);
    adv(188);
    chk("mid_tick_8th", mid_tick, 1);
    chk("mid_with_sample", sample_tick, 1);
    chk("ticks_to_mid", ns, 8);
    chk("mid_once", nm, 1);
    chk("no_early_bit", nb, 0);
    adv(216);
    chk("bit_tick_16th", bit_tick, 1);
    chk("ticks_to_bit", ns, 16);
    chk("idx_wrap", sample_idx, 0);
    clr();
    adv(432);
    chk("bit_period", bit_tick, 1);
    chk("bits_in_432", nb, 1);
    chk("ticks_in_432", ns, 16);
    chk("mids_in_432", nm, 1);

    adv(10);
    resync = 1'b1;
    adv(1);
    resync = 1'b0;
    chk("rs10_no_tick", sample_tick, 0);
    chk("rs10_idx", sample_idx, 0);
    clr();
    adv(26);
    chk("rs10_quiet", ns, 0);
    adv(1);
    chk("rs10_tick", sample_tick, 1);

    adv(26);
    resync = 1'b1;
    adv(1);
    resync = 1'b0;
    chk("rstc_no_tick", sample_tick, 0);
    chk("rstc_idx", sample_idx, 0);
    clr();
    adv(26);
    chk("rstc_quiet", ns, 0);
    adv(1);
    chk("rstc_tick", sample_tick, 1);

    baud_sel = 3'd3;
    clr();
    adv(26);
    chk("sel_ignored_quiet", ns, 0);
    adv(1);
    chk("sel_ignored_tick", sample_tick, 1);
    chk("sel_ignored_div", div_val, 26);
    enable = 1'b0;
    adv(1);
    chk("div_sel3", div_val, 325);
    chk("dis_tick", sample_tick, 0);
    chk("dis_idx", sample_idx, 0);
    enable = 1'b1;
    clr();
    adv(325);
    chk("p326_quiet", ns, 0);
    adv(1);
    chk("p326_tick", sample_tick, 1);
    chk("p326_idx", sample_idx, 1);

    adv(100);
    enable = 1'b0;
    adv(1);
    chk("drop_mid_tick", sample_tick, 0);
    chk("drop_mid_idx", sample_idx, 0);
    enable = 1'b1;
    clr();
    adv(325);
    chk("restart_quiet", ns, 0);
    adv(1);
    chk("restart_tick", sample_tick, 1);
    adv(325);
    enable = 1'b0;
    clr();
    adv(1);
    chk("drop_tc_tick", sample_tick, 0);
    chk("drop_tc_idx", sample_idx, 0);

    baud_sel = 3'd7;
    adv(1);
    enable = 1'b1;
    adv(27);
    chk("pre_reset_tick", sample_tick, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tick", sample_tick, 0);
    chk("async_rst_idx", sample_idx, 0);
    chk("async_rst_div", div_val, 10416);
    clr();
    adv(2);
    chk("held_rst_ticks", ns, 0);
    reset = 1'b1;

`ifdef BAUD_TICK_GEN_DIV_OVR_EN
    enable      = 1'b0;
    div_ovr_sel = 1'b1;
    div_ovr     = 16'd4;
    adv(1);
    chk("ovr_div4", div_val, 4);
    enable = 1'b1;
    clr();
    adv(4);
    chk("ovr4_quiet", ns, 0);
    adv(1);
    chk("ovr4_tick", sample_tick, 1);
    adv(75);
    chk("ovr4_bit80", bit_tick, 1);
    chk("ovr4_bits", nb, 1);
    chk("ovr4_ticks", ns, 16);
    div_ovr = 16'd0;
    enable  = 1'b0;
    adv(1);
    chk("ovr_div0", div_val, 0);
    enable = 1'b1;
    clr();
    adv(16);
    chk("ovr0_ticks", ns, 16);
    chk("ovr0_bits", nb, 1);
    chk("ovr0_bit16", bit_tick, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
